// File: rtl/dcache_sram_nway_if.sv
`default_nettype none
// dcache_sram_nway_if -- access/lookup bus between the cache controller and the storage array.
// Revision: 1.0
interface dcache_sram_nway_if #(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
);
  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);
  localparam int BE_W  = LINE_W / 8;

  logic              enable_i;
  logic              write_i;
  logic              fill_i;
  logic              dirty_i;
  logic [IDX_W-1:0]  addr_i;
  logic [TAG_W-1:0]  tag_i;
  logic [LINE_W-1:0] data_i;
  logic [BE_W-1:0]   be_i;
  logic              flush_i;
  logic              hit_o;
  logic [AGE_W-1:0]  way_o;
  logic [TAG_W-1:0]  tag_o;
  logic [LINE_W-1:0] data_o;
  logic              valid_o;
  logic              dirty_o;
  logic              busy_o;

  modport master (
    output enable_i, write_i, fill_i, dirty_i, addr_i, tag_i, data_i, be_i, flush_i,
    input  hit_o, way_o, tag_o, data_o, valid_o, dirty_o, busy_o
  );

  modport slave (
    input  enable_i, write_i, fill_i, dirty_i, addr_i, tag_i, data_i, be_i, flush_i,
    output hit_o, way_o, tag_o, data_o, valid_o, dirty_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/dcache_sram_nway.sv
`default_nettype none
// dcache_sram_nway -- N-way set-associative cache storage with age-counter LRU and flush walker.
// Revision: 1.0
module dcache_sram_nway #(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  dcache_sram_nway_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);
  localparam int BE_W  = LINE_W / 8;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);
  localparam logic [AGE_W-1:0] OLDEST   = AGE_W'(WAYS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] walk_set;

  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [LINE_W-1:0] data_mem  [SETS][WAYS];
  logic              valid_mem [SETS][WAYS];
  logic              dirty_mem [SETS][WAYS];
  logic [AGE_W-1:0]  age_mem   [SETS][WAYS];

  logic             busy;
  logic             access;
  logic             hit_any;
  logic             hit;
  logic [AGE_W-1:0] hit_way;
  logic [AGE_W-1:0] victim_way;
  logic [AGE_W-1:0] sel_way;
  logic [AGE_W-1:0] touch_age;
  logic [AGE_W-1:0] age_nxt [WAYS];
  logic             do_fill;
  logic             do_merge;
  logic             do_touch;

  assign busy   = (state == WALK);
  assign access = bus.enable_i & ~busy;

  // Descending scans so the lowest matching index is the last one written.
  always_comb begin
    hit_any    = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_mem[bus.addr_i][w] && (tag_mem[bus.addr_i][w] == bus.tag_i)) begin
        hit_any = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (age_mem[bus.addr_i][w] == OLDEST) victim_way = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[bus.addr_i][w]) victim_way = AGE_W'(w);
    end
  end

  assign hit     = access & hit_any;
  assign sel_way = hit ? hit_way : victim_way;

  assign do_fill  = access & bus.write_i & bus.fill_i;
  assign do_merge = hit & bus.write_i & ~bus.fill_i;
  assign do_touch = do_fill | hit;

  always_comb begin
    touch_age = age_mem[bus.addr_i][sel_way];
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == sel_way)
        age_nxt[w] = '0;
      else if (age_mem[bus.addr_i][w] < touch_age)
        age_nxt[w] = age_mem[bus.addr_i][w] + AGE_W'(1);
      else
        age_nxt[w] = age_mem[bus.addr_i][w];
    end
  end

  assign bus.hit_o   = hit;
  assign bus.way_o   = sel_way;
  assign bus.tag_o   = tag_mem[bus.addr_i][sel_way];
  assign bus.data_o  = data_mem[bus.addr_i][sel_way];
  assign bus.valid_o = valid_mem[bus.addr_i][sel_way];
  assign bus.dirty_o = dirty_mem[bus.addr_i][sel_way];
  assign bus.busy_o  = busy;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.flush_i) state_nxt = WALK;
      WALK:    if (walk_set == LAST_SET) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SETS is a power of two, so the counter wraps back to 0 as the walk ends.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      walk_set <= '0;
    end else begin
      state <= state_nxt;
      if (state == WALK) walk_set <= walk_set + IDX_W'(1);
    end
  end

  for (genvar s = 0; s < SETS; s++) begin : g_set
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [TAG_W-1:0]  tag_q;
      logic [LINE_W-1:0] data_q;
      logic              valid_q;
      logic              dirty_q;
      logic [AGE_W-1:0]  age_q;
      logic              set_here;
      logic              way_here;

      assign set_here = (bus.addr_i == IDX_W'(s));
      assign way_here = set_here && (sel_way == AGE_W'(w));

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          tag_q   <= '0;
          data_q  <= '0;
          valid_q <= 1'b0;
          dirty_q <= 1'b0;
          age_q   <= AGE_W'(w);
        end else if (busy) begin
          if (walk_set == IDX_W'(s)) begin
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            age_q   <= AGE_W'(w);
          end
        end else if (set_here) begin
          if (do_touch) age_q <= age_nxt[w];
          if (way_here && do_fill) begin
            tag_q   <= bus.tag_i;
            data_q  <= bus.data_i;
            valid_q <= 1'b1;
            dirty_q <= bus.dirty_i;
          end
          if (way_here && do_merge) begin
            for (int k = 0; k < BE_W; k++) begin
              if (bus.be_i[k]) data_q[8*k +: 8] <= bus.data_i[8*k +: 8];
            end
            dirty_q <= 1'b1;
          end
        end
      end

      assign tag_mem[s][w]   = tag_q;
      assign data_mem[s][w]  = data_q;
      assign valid_mem[s][w] = valid_q;
      assign dirty_mem[s][w] = dirty_q;
      assign age_mem[s][w]   = age_q;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dcache_sram_nway.sv
`default_nettype none
// tb_dcache_sram_nway -- directed checks of lookup, LRU, byte-write, fill and flush on 2-way and 4-way arrays.
// Revision: 1.0
module tb_dcache_sram_nway;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  dcache_sram_nway_if #(.SETS(16), .WAYS(2), .TAG_W(23), .LINE_W(256)) b2 ();
  dcache_sram_nway_if #(.SETS(4),  .WAYS(4), .TAG_W(8),  .LINE_W(32))  b4 ();

  dcache_sram_nway #(.SETS(16), .WAYS(2), .TAG_W(23), .LINE_W(256)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b2.slave)
  );

  dcache_sram_nway #(.SETS(4), .WAYS(4), .TAG_W(8), .LINE_W(32)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b4.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Presents one access mid-cycle; the following rising edge commits it.
  task automatic acc2(input logic en, input logic wr, input logic fl, input logic dty,
                      input logic [3:0] a, input logic [22:0] t, input logic [255:0] d,
                      input logic [31:0] be, input logic flush);
    @(negedge clk);
    b2.enable_i = en; b2.write_i = wr; b2.fill_i = fl; b2.dirty_i = dty;
    b2.addr_i = a; b2.tag_i = t; b2.data_i = d; b2.be_i = be; b2.flush_i = flush;
    #1;
  endtask

  task automatic acc4(input logic en, input logic wr, input logic fl,
                      input logic [1:0] a, input logic [7:0] t, input logic [31:0] d);
    @(negedge clk);
    b4.enable_i = en; b4.write_i = wr; b4.fill_i = fl; b4.dirty_i = 1'b0;
    b4.addr_i = a; b4.tag_i = t; b4.data_i = d; b4.be_i = '0; b4.flush_i = 1'b0;
    #1;
  endtask

  logic [255:0] line_a;
  logic [255:0] line_b;
  logic [255:0] line_c;
  logic [255:0] wr_data;
  logic [255:0] merged;
  int           busy_cnt;
  logic         hit_seen;
  logic         any_valid;

  initial begin
    total = 0;
    bad   = 0;
    line_a  = {8{32'hA1A2A3A4}};
    line_b  = {8{32'hB1B2B3B4}};
    line_c  = {8{32'hC0C1C2C3}};
    wr_data = {{31{8'hEE}}, 8'hFF};
    merged  = {line_a[255:8], 8'hFF};

    rst = 1'b1;
    b2.enable_i = 0; b2.write_i = 0; b2.fill_i = 0; b2.dirty_i = 0;
    b2.addr_i = '0; b2.tag_i = '0; b2.data_i = '0; b2.be_i = '0; b2.flush_i = 0;
    b4.enable_i = 0; b4.write_i = 0; b4.fill_i = 0; b4.dirty_i = 0;
    b4.addr_i = '0; b4.tag_i = '0; b4.data_i = '0; b4.be_i = '0; b4.flush_i = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    acc2(1, 0, 0, 0, 4'd3, 23'h5A, '0, '0, 0);
    chk("rst_hit",   b2.hit_o,   0);
    chk("rst_valid", b2.valid_o, 0);
    chk("rst_way",   b2.way_o,   0);
    chk("rst_busy",  b2.busy_o,  0);
    chk("rst_dirty", b2.dirty_o, 0);
    chk("rst_tag",   b2.tag_o,   0);
    chk("rst_data",  b2.data_o,  0);

    acc2(1, 1, 1, 0, 4'd3, 23'h5A, line_a, '0, 0);
    chk("fill1_way", b2.way_o, 0);
    acc2(1, 1, 1, 0, 4'd3, 23'h6B, line_b, '0, 0);
    chk("fill2_way", b2.way_o, 1);
    chk("fill2_hit", b2.hit_o, 0);

    acc2(1, 0, 0, 0, 4'd3, 23'h5A, '0, '0, 0);
    chk("rd5A_hit",   b2.hit_o,   1);
    chk("rd5A_way",   b2.way_o,   0);
    chk("rd5A_data",  b2.data_o,  line_a);
    chk("rd5A_valid", b2.valid_o, 1);
    chk("rd5A_dirty", b2.dirty_o, 0);

    acc2(1, 0, 0, 0, 4'd3, 23'h7C, '0, '0, 0);
    chk("rd7C_hit",  b2.hit_o,  0);
    chk("rd7C_way",  b2.way_o,  1);
    chk("rd7C_tag",  b2.tag_o,  23'h6B);
    chk("rd7C_data", b2.data_o, line_b);

    acc2(1, 1, 0, 0, 4'd3, 23'h5A, wr_data, 32'h1, 0);
    chk("wrhit_hit", b2.hit_o, 1);
    chk("wrhit_way", b2.way_o, 0);
    acc2(1, 1, 0, 0, 4'd3, 23'h7C, {32{8'h55}}, 32'hFFFF_FFFF, 0);
    chk("wrmiss_hit", b2.hit_o, 0);

    acc2(1, 0, 0, 0, 4'd3, 23'h5A, '0, '0, 0);
    chk("merge_data",  b2.data_o,  merged);
    chk("merge_dirty", b2.dirty_o, 1);
    acc2(1, 0, 0, 0, 4'd3, 23'h7C, '0, '0, 0);
    chk("wrmiss_way",  b2.way_o,  1);
    chk("wrmiss_data", b2.data_o, line_b);

    acc2(1, 1, 1, 1, 4'd3, 23'h6B, line_c, '0, 0);
    chk("refill_hit", b2.hit_o, 1);
    chk("refill_way", b2.way_o, 1);
    acc2(1, 0, 0, 0, 4'd3, 23'h6B, '0, '0, 0);
    chk("rd6B_data",  b2.data_o,  line_c);
    chk("rd6B_dirty", b2.dirty_o, 1);
    acc2(0, 0, 0, 0, 4'd3, 23'h5A, '0, '0, 0);
    chk("noen_hit", b2.hit_o, 0);

    acc2(1, 0, 0, 0, 4'd3, 23'h5A, '0, '0, 1);
    chk("flush_cyc_busy", b2.busy_o, 0);
    chk("flush_cyc_hit",  b2.hit_o,  1);
    busy_cnt = 0;
    hit_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      acc2(1, 0, 0, 0, 4'd3, 23'h5A, '0, '0, 0);
      if (b2.busy_o !== 1'b1) break;
      busy_cnt++;
      if (b2.hit_o !== 1'b0) hit_seen = 1'b1;
    end
    chk("busy_len",  busy_cnt, 16);
    chk("busy_hit",  hit_seen, 0);
    chk("post_hit",  b2.hit_o,   0);
    chk("post_val",  b2.valid_o, 0);
    chk("post_way",  b2.way_o,   0);
    chk("post_tag",  b2.tag_o,   23'h5A);
    any_valid = 1'b0;
    for (int s = 0; s < 16; s++) begin
      acc2(1, 0, 0, 0, 4'(s), 23'h6B, '0, '0, 0);
      if (b2.hit_o !== 1'b0 || b2.valid_o !== 1'b0) any_valid = 1'b1;
    end
    chk("post_all_miss", any_valid, 0);

    acc2(1, 1, 1, 1, 4'd5, 23'h11, line_a, '0, 0);
    acc2(1, 1, 1, 1, 4'd5, 23'h22, line_b, '0, 0);
    acc2(0, 0, 0, 0, 4'd5, 23'h22, '0, '0, 1);
    repeat (5) acc2(0, 0, 0, 0, 4'd5, 23'h22, '0, '0, 0);
    chk("walk_busy", b2.busy_o, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", b2.busy_o, 0);
    @(negedge clk);
    rst = 1'b0;
    acc2(1, 0, 0, 0, 4'd5, 23'h22, '0, '0, 0);
    chk("abort_hit",  b2.hit_o,  0);
    chk("abort_way",  b2.way_o,  0);
    chk("abort_tag",  b2.tag_o,  0);
    chk("abort_data", b2.data_o, 0);
    acc2(1, 1, 1, 0, 4'd5, 23'h33, line_a, '0, 0);
    chk("abort_fill1_way", b2.way_o, 0);
    acc2(1, 1, 1, 0, 4'd5, 23'h44, line_b, '0, 0);
    chk("abort_fill2_way", b2.way_o, 1);
    acc2(1, 0, 0, 0, 4'd5, 23'h55, '0, '0, 0);
    chk("abort_victim", b2.way_o, 0);
    chk("abort_vtag",   b2.tag_o, 23'h33);
    acc2(0, 0, 0, 0, 4'd0, 23'h0, '0, '0, 0);

    acc4(1, 1, 1, 2'd0, 8'd1, 32'h1111_1111);
    chk("w4_fill1", b4.way_o, 0);
    acc4(1, 1, 1, 2'd0, 8'd2, 32'h2222_2222);
    chk("w4_fill2", b4.way_o, 1);
    acc4(1, 1, 1, 2'd0, 8'd3, 32'h3333_3333);
    chk("w4_fill3", b4.way_o, 2);
    acc4(1, 1, 1, 2'd0, 8'd4, 32'h4444_4444);
    chk("w4_fill4", b4.way_o, 3);
    acc4(1, 0, 0, 2'd0, 8'd1, 32'h0);
    chk("w4_rd1_hit", b4.hit_o, 1);
    chk("w4_rd1_way", b4.way_o, 0);
    acc4(1, 0, 0, 2'd0, 8'd9, 32'h0);
    chk("w4_victim_way", b4.way_o, 1);
    chk("w4_victim_tag", b4.tag_o, 8'd2);
    acc4(1, 1, 1, 2'd0, 8'd5, 32'h5555_5555);
    chk("w4_fill5_way", b4.way_o, 1);
    acc4(1, 0, 0, 2'd0, 8'd5, 32'h0);
    chk("w4_rd5_hit",  b4.hit_o,  1);
    chk("w4_rd5_data", b4.data_o, 32'h5555_5555);
    acc4(1, 0, 0, 2'd0, 8'd2, 32'h0);
    chk("w4_rd2_hit",  b4.hit_o, 0);
    chk("w4_next_vic", b4.way_o, 2);
    chk("w4_next_tag", b4.tag_o, 8'd3);
    acc4(1, 0, 0, 2'd0, 8'd4, 32'h0);
    chk("w4_rd4_way", b4.way_o, 3);
    acc4(1, 0, 0, 2'd0, 8'd9, 32'h0);
    chk("w4_last_vic", b4.way_o, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
